// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Receive side of a neuron spike line. It synchronises the asynchronous
//   spike input and counts rising edges over a fixed window of WINDOW clk
//   cycles. At the end of each window it publishes the count on rate_out,
//   a saturation flag on overflow, and a 7-segment hex glyph on seg_out.
//   rate_valid pulses for one cycle each time these outputs update.
//
//   Optional feature: define SPIKE_GLITCH_FILTER_EN to require two
//   consecutive synchronised high cycles before a rising edge is counted.
//   Pulses shorter than two cycles are then ignored, and the increment
//   latency grows by one cycle.
module spike_rate_decoder #(
  parameter int unsigned WINDOW = 32'd10_000_000,
  parameter int unsigned CNT_W  = 32'd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             enable,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             overflow,
  output logic [7:0]       seg_out
);

  localparam int unsigned      WIN_W    = (WINDOW > 32'd1) ? $clog2(WINDOW) : 32'd1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 32'd1);
  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};
  // The glyph decoder needs at least a nibble even when CNT_W < 4.
  localparam int unsigned      EXT_W    = (CNT_W > 32'd4) ? CNT_W : 32'd4;
  localparam logic [7:0]       SEG_ZERO = 8'h3F;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Build {dp,g,f,e,d,c,b,a}. Counts above 15 show 'F' with the dp lit.
  // A saturated window also lights the dp.
  function automatic logic [7:0] seg_encode(input logic [CNT_W-1:0] rate,
                                            input logic             ovf);
    logic [EXT_W-1:0] ext;
    logic [6:0]       glyph;
    logic             dp;
    ext = EXT_W'(rate);
    if (ext > EXT_W'(32'd15)) begin
      glyph = 7'h71;
      dp    = 1'b1;
    end else begin
      case (ext[3:0])
        4'h0:    glyph = 7'h3F;
        4'h1:    glyph = 7'h06;
        4'h2:    glyph = 7'h5B;
        4'h3:    glyph = 7'h4F;
        4'h4:    glyph = 7'h66;
        4'h5:    glyph = 7'h6D;
        4'h6:    glyph = 7'h7D;
        4'h7:    glyph = 7'h07;
        4'h8:    glyph = 7'h7F;
        4'h9:    glyph = 7'h6F;
        4'hA:    glyph = 7'h77;
        4'hB:    glyph = 7'h7C;
        4'hC:    glyph = 7'h39;
        4'hD:    glyph = 7'h5E;
        4'hE:    glyph = 7'h79;
        default: glyph = 7'h71;
      endcase
      dp = ovf;
    end
    return {dp, glyph};
  endfunction

  // Synchroniser and edge-history flops
  logic s1_q, s2_q, s3_q;
  logic edge_s;

  // State and datapath registers
  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [7:0]       seg_q, seg_d;

  // Two-flop synchroniser followed by one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= spike_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

`ifdef SPIKE_GLITCH_FILTER_EN
  logic s4_q;

  // Extra history flop so that an edge needs two consecutive high samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s4_q <= 1'b0;
    end else begin
      s4_q <= s3_q;
    end
  end

  assign edge_s = s2_q & s3_q & ~s4_q;
`else
  assign edge_s = s2_q & ~s3_q;
`endif

  // Measurement FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window counter, accumulator, published result and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q  <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      rate_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      seg_q      <= SEG_ZERO;
    end else begin
      win_cnt_q  <= win_cnt_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      rate_q     <= rate_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      seg_q      <= seg_d;
    end
  end

  // Next-state logic: window sequencing, saturating count, result latch
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    rate_d     = rate_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        win_cnt_d  = '0;
        acc_d      = '0;
        ovf_pend_d = 1'b0;
        if (enable) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (!enable) begin
          // The partial window is discarded and the published result is kept.
          state_d    = IDLE;
          win_cnt_d  = '0;
          acc_d      = '0;
          ovf_pend_d = 1'b0;
        end else begin
          state_d = RUN;
          if (edge_s) begin
            if (acc_q == ACC_MAX) begin
              acc_d      = acc_q;
              ovf_pend_d = 1'b1;
            end else begin
              acc_d      = acc_q + CNT_W'(1'b1);
              ovf_pend_d = ovf_pend_q;
            end
          end else begin
            acc_d      = acc_q;
            ovf_pend_d = ovf_pend_q;
          end

          if (win_cnt_q == WIN_LAST) begin
            // acc_d/ovf_pend_d already include an edge seen on the
            // terminal cycle, so that edge counts in the closing window.
            rate_d     = acc_d;
            ovf_d      = ovf_pend_d;
            valid_d    = 1'b1;
            acc_d      = '0;
            ovf_pend_d = 1'b0;
            win_cnt_d  = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1'b1);
          end
        end
      end

      default: begin
        state_d    = IDLE;
        win_cnt_d  = '0;
        acc_d      = '0;
        ovf_pend_d = 1'b0;
      end
    endcase

    // The glyph is computed from the incoming values so that seg_out
    // changes on the same edge as rate_out.
    seg_d = seg_encode(rate_d, ovf_d);
  end

  assign rate_out   = rate_q;
  assign rate_valid = valid_q;
  assign overflow   = ovf_q;
  assign seg_out    = seg_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder
//   Three instances share clk, rst and spike_in, and each has its own enable:
//     u16 : WINDOW=16, CNT_W=8
//     u64 : WINDOW=64, CNT_W=8 (five 4-cycle spikes and twenty 3-cycle spikes
//           do not fit in 16 cycles)
//     u3  : WINDOW=32, CNT_W=3 (ten rising edges need more than 16 cycles)
//   Inputs are driven 1 ns after the rising edge. Outputs are sampled at
//   the same point.
module tb_spike_rate_decoder;

  logic       clk;
  logic       rst;
  logic       spike;
  logic       en16, en64, en3;
  logic [7:0] rate16, rate64;
  logic [2:0] rate3;
  logic       rv16, rv64, rv3;
  logic       ovf16, ovf64, ovf3;
  logic [7:0] seg16, seg64, seg3;

  int checks;
  int errors;

  spike_rate_decoder #(.WINDOW(32'd16), .CNT_W(32'd8)) u16 (
    .clk(clk), .rst(rst), .spike_in(spike), .enable(en16),
    .rate_out(rate16), .rate_valid(rv16), .overflow(ovf16), .seg_out(seg16));

  spike_rate_decoder #(.WINDOW(32'd64), .CNT_W(32'd8)) u64 (
    .clk(clk), .rst(rst), .spike_in(spike), .enable(en64),
    .rate_out(rate64), .rate_valid(rv64), .overflow(ovf64), .seg_out(seg64));

  spike_rate_decoder #(.WINDOW(32'd32), .CNT_W(32'd3)) u3 (
    .clk(clk), .rst(rst), .spike_in(spike), .enable(en3),
    .rate_out(rate3), .rate_valid(rv3), .overflow(ovf3), .seg_out(seg3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rv_of(input int sel);
    case (sel)
      0:       return rv16;
      1:       return rv64;
      default: return rv3;
    endcase
  endfunction

  // Advance until the selected instance shows rate_valid; cyc=-1 on timeout.
  task automatic wait_valid(input int sel, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (rv_of(sel) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      spike = 1'b1;
      repeat (hi) tick();
      spike = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; spike = 1'b0; en16 = 1'b0; en64 = 1'b0; en3 = 1'b0;
    repeat (3) tick();
    checks++; if (rate16 !== 8'd0) begin errors++; $display("FAIL reset_rate got %0d want 0", rate16); end
    checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rv16); end
    checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf16); end
    checks++; if (seg16 !== 8'h3F) begin errors++; $display("FAIL reset_seg got %h want 3f", seg16); end
    checks++; if (seg3 !== 8'h3F) begin errors++; $display("FAIL reset_seg3 got %h want 3f", seg3); end
    rst = 1'b0;
    tick();
  endtask

  // Five 2-high/2-low spikes in one window.
  task automatic test_count_five();
    int c;
    en64 = 1'b1;
    wait_valid(1, 100, c);
    checks++; if (c < 0) begin errors++; $display("FAIL five_sync_timeout got %0d want >0", c); end
    pulses(5, 2, 2);
    wait_valid(1, 100, c);
    checks++; if (c < 0) begin errors++; $display("FAIL five_timeout got %0d want >0", c); end
    checks++; if (rate64 !== 8'd5) begin errors++; $display("FAIL five_rate got %0d want 5", rate64); end
    checks++; if (seg64 !== 8'h6D) begin errors++; $display("FAIL five_seg got %h want 6d", seg64); end
    checks++; if (ovf64 !== 1'b0) begin errors++; $display("FAIL five_ovf got %b want 0", ovf64); end
    tick();
    checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL five_pulse_width got %b want 0", rv64); end
  endtask

  // Twenty spikes with a period of 3 in a 64-cycle window.
  task automatic test_count_twenty();
    int c;
    pulses(20, 1, 2);
    wait_valid(1, 100, c);
    checks++; if (c < 0) begin errors++; $display("FAIL twenty_timeout got %0d want >0", c); end
    checks++; if (rate64 !== 8'd20) begin errors++; $display("FAIL twenty_rate got %0d want 20", rate64); end
    checks++; if (seg64 !== 8'hF1) begin errors++; $display("FAIL twenty_seg got %h want f1", seg64); end
    checks++; if (ovf64 !== 1'b0) begin errors++; $display("FAIL twenty_ovf got %b want 0", ovf64); end
    en64 = 1'b0;
  endtask

  // A spike held high across three windows is counted once.
  task automatic test_held_high();
    int c;
    en16 = 1'b1;
    wait_valid(0, 40, c);
    spike = 1'b1;
    wait_valid(0, 40, c);
    checks++; if (rate16 !== 8'd1) begin errors++; $display("FAIL held_w1 got %0d want 1", rate16); end
    checks++; if (seg16 !== 8'h06) begin errors++; $display("FAIL held_seg1 got %h want 06", seg16); end
    wait_valid(0, 40, c);
    checks++; if (rate16 !== 8'd0) begin errors++; $display("FAIL held_w2 got %0d want 0", rate16); end
    wait_valid(0, 40, c);
    checks++; if (c < 0) begin errors++; $display("FAIL held_timeout got %0d want >0", c); end
    checks++; if (rate16 !== 8'd0) begin errors++; $display("FAIL held_w3 got %0d want 0", rate16); end
    checks++; if (seg16 !== 8'h3F) begin errors++; $display("FAIL held_seg3 got %h want 3f", seg16); end
    spike = 1'b0;
    en16 = 1'b0;
    repeat (3) tick();
  endtask

  // With CNT_W=3, ten spikes saturate the count at 7 and set overflow.
  task automatic test_saturation();
    int c;
    en3 = 1'b1;
    wait_valid(2, 60, c);
    pulses(10, 1, 1);
    wait_valid(2, 60, c);
    checks++; if (c < 0) begin errors++; $display("FAIL sat_timeout got %0d want >0", c); end
    checks++; if (rate3 !== 3'd7) begin errors++; $display("FAIL sat_rate got %0d want 7", rate3); end
    checks++; if (ovf3 !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", ovf3); end
    checks++; if (seg3 !== 8'h87) begin errors++; $display("FAIL sat_seg got %h want 87", seg3); end
    wait_valid(2, 60, c);
    checks++; if (rate3 !== 3'd0) begin errors++; $display("FAIL sat_quiet_rate got %0d want 0", rate3); end
    checks++; if (ovf3 !== 1'b0) begin errors++; $display("FAIL sat_quiet_ovf got %b want 0", ovf3); end
    checks++; if (seg3 !== 8'h3F) begin errors++; $display("FAIL sat_quiet_seg got %h want 3f", seg3); end
    en3 = 1'b0;
  endtask

  // Dropping enable mid-window discards the partial count.
  task automatic test_enable_drop();
    int c;
    int npulse;
    en16 = 1'b1;
    wait_valid(0, 40, c);
    pulses(3, 1, 2);
    wait_valid(0, 40, c);
    checks++; if (rate16 !== 8'd3) begin errors++; $display("FAIL drop_pre_rate got %0d want 3", rate16); end
    // Window cycle 0 now. Two spikes, then stop at win_cnt=8.
    pulses(2, 1, 2);
    repeat (2) tick();
    en16 = 1'b0;
    npulse = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rv16 === 1'b1) npulse++;
    end
    checks++; if (npulse !== 0) begin errors++; $display("FAIL drop_no_valid got %0d want 0", npulse); end
    checks++; if (rate16 !== 8'd3) begin errors++; $display("FAIL drop_hold got %0d want 3", rate16); end
    en16 = 1'b1;
    wait_valid(0, 40, c);
    // One IDLE->RUN cycle plus sixteen window cycles.
    checks++; if (c !== 17) begin errors++; $display("FAIL drop_reenable_latency got %0d want 17", c); end
    checks++; if (rate16 !== 8'd0) begin errors++; $display("FAIL drop_discard got %0d want 0", rate16); end
    tick();
    checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL drop_pulse_width got %b want 0", rv16); end
  endtask

  // An asynchronous reset mid-run clears outputs at once, then counting resumes.
  task automatic test_reset_mid_run();
    int c;
    wait_valid(0, 40, c);
    pulses(4, 1, 2);
    wait_valid(0, 40, c);
    checks++; if (rate16 !== 8'd4) begin errors++; $display("FAIL mid_pre_rate got %0d want 4", rate16); end
    spike = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rate16 !== 8'd0) begin errors++; $display("FAIL mid_rate got %0d want 0", rate16); end
    checks++; if (seg16 !== 8'h3F) begin errors++; $display("FAIL mid_seg got %h want 3f", seg16); end
    checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", rv16); end
    checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", ovf16); end
    spike = 1'b0;
    tick();
    rst = 1'b0;
    wait_valid(0, 40, c);
    checks++; if (c !== 17) begin errors++; $display("FAIL mid_resume_latency got %0d want 17", c); end
    checks++; if (rate16 !== 8'd0) begin errors++; $display("FAIL mid_resume_rate got %0d want 0", rate16); end
    en16 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count_five();
    test_count_twenty();
    test_held_high();
    test_saturation();
    test_enable_drop();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
